alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Writeback stage directly downstream of the 32-bit ALU.
- Captures ALUOut, the flag nibble {Z,C,N,O} and the destination select each cycle the ALU result is valid.
- Evaluates a 4-bit condition code against the captured flags and buffers results in a small FIFO.
- Drives the register file with a valid/ready handshake and a write-enable gated by the condition result.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- DEST_W, 3, width of destination register select.

Ports:
- Clock  in  1  rising-edge clock, single clock domain.
- Reset  in  1  synchronous, active-low reset; sampled on rising edge of Clock.
- InValid  in  1  ALU result valid this cycle.
- InReady  out  1  stage can accept; equals !full.
- ALUOut  in  32  ALU result word.
- FlagsIn  in  4  flags {Z,C,N,O}, same bit order as ALU FlagsOut.
- DestSel  in  DEST_W  destination register index.
- CondSel  in  4  condition code for this result.
- OutValid  out  1  head entry valid.
- OutReady  in  1  register file accepts head entry.
- OutData  out  32  head result word.
- OutFlags  out  4  head flags.
- OutDest  out  DEST_W  head destination.
- OutWrite  out  1  condition passed; register file writes only if OutValid & OutReady & OutWrite.
- Count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Push = InValid & InReady. Pop = OutValid & OutReady.
- Condition is evaluated combinationally at push time; the pass bit is stored with the entry.
- Condition codes:
  - 0 AL: 1
  - 1 EQ: Z
  - 2 NE: !Z
  - 3 CS: C
  - 4 CC: !C
  - 5 MI: N
  - 6 PL: !N
  - 7 VS: O
  - 8 VC: !O
  - 9 HI: C&!Z
  - 10 LS: !C|Z
  - 11 GE: N==O
  - 12 LT: N!=O
  - 13 GT: !Z&(N==O)
  - 14 LE: Z|(N!=O)
  - 15 NV: 0
- Latency: an entry pushed in cycle t shows OutValid=1 in cycle t+1 (bypass compiled out).
- Storage is a circular buffer. Read and write pointers wrap modulo DEPTH. Count is tracked separately: full when Count==DEPTH, empty when Count==0.
- Simultaneous push and pop (not empty, not full): Count unchanged, both pointers advance.
- Full: InReady=0 and any push attempt is ignored. InReady does not depend on OutReady; there is no combinational ready path.
- Empty: OutValid=0. OutData, OutFlags, OutDest and OutWrite read 0 when empty.
- Output fields are stable while OutValid=1 and OutReady=0.
- Reset (Reset=0 at a clock edge):
  - Pointers, Count and all stored entries clear to 0.
  - OutValid=0, InReady=1 on the following cycle.
  - Any in-flight entry is discarded, including a mid-handshake push or pop in the reset cycle.
- Values on ALUOut, FlagsIn, DestSel and CondSel are don't-care while InValid=0.

Optional Feature:
- Macro ALU_RESULT_BYPASS_EN.
- Defined: when Count==0 and InValid=1, the Out* fields are driven directly from the inputs in the same cycle, with OutValid=InValid and OutWrite from live condition evaluation.
  - If OutReady=1 that cycle, the entry is consumed without being stored; Count stays 0.
  - If OutReady=0, it is pushed normally.
- Undefined: 1-cycle minimum latency as specified above.

Decomposition:
- Shared package holds:
  - Condition-code localparams COND_AL..COND_NV (4'd0..4'd15).
  - Flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_O=0.
  - Entry struct {data[31:0], flags[3:0], dest, pass}.
- One sub-module, alu_cond_eval: combinational (flags, cond) -> pass. It is reused later by the branch unit.

Test Plan:
- Reset then push ALUOut=32'h0000_0005, Flags=4'b0000, Dest=3, Cond=AL -> next cycle OutValid=1, OutData=5, OutDest=3, OutWrite=1, Count=1.
- Push two entries with OutReady=0 -> Count=2, InReady=0; third push with data 32'hDEAD_BEEF is dropped; pop twice -> original two entries returned in order, then OutValid=0.
- Flags=4'b1000 (Z): Cond=EQ -> OutWrite=1; Cond=NE -> OutWrite=0. Flags=4'b0011 (N,O): Cond=GE -> 1; Cond=LT -> 0; Cond=GT -> 1.
- Count=1, push and pop in the same cycle for 8 consecutive cycles -> Count stays 1, pointers wrap, data emerges in push order.
- Count=2, assert Reset=0 for one cycle while InValid=1 and OutReady=1 -> next cycle Count=0, OutValid=0, InReady=1, OutData=0.
- ALU_RESULT_BYPASS_EN defined, empty, InValid=1, OutReady=1, ALUOut=32'h1234_5678 -> OutValid=1 and OutData=32'h1234_5678 in the same cycle; Count remains 0.

Source files
------------

// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU writeback stage and the condition evaluator.
package alu_result_stage_pkg;

  // Condition codes
  localparam logic [3:0] COND_AL = 4'd0;
  localparam logic [3:0] COND_EQ = 4'd1;
  localparam logic [3:0] COND_NE = 4'd2;
  localparam logic [3:0] COND_CS = 4'd3;
  localparam logic [3:0] COND_CC = 4'd4;
  localparam logic [3:0] COND_MI = 4'd5;
  localparam logic [3:0] COND_PL = 4'd6;
  localparam logic [3:0] COND_VS = 4'd7;
  localparam logic [3:0] COND_VC = 4'd8;
  localparam logic [3:0] COND_HI = 4'd9;
  localparam logic [3:0] COND_LS = 4'd10;
  localparam logic [3:0] COND_GE = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12;
  localparam logic [3:0] COND_GT = 4'd13;
  localparam logic [3:0] COND_LE = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // Flag nibble bit positions {Z,C,N,O}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  // Widest destination select an entry can carry; narrower selects are zero-extended.
  localparam int DEST_MAX_W = 8;

  typedef struct packed {
    logic [31:0]           data;
    logic [3:0]            flags;
    logic [DEST_MAX_W-1:0] dest;
    logic                  pass;
  } entry_t;

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational condition-code evaluator: (flags, cond) -> pass.
// Shared with the branch unit.
module alu_cond_eval
  import alu_result_stage_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       pass
);

  logic z, c, n, o;
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign o = flags[FLAG_O];

  // Decode the condition against the flag nibble.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_AL: pass = 1'b1;
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = o;
      COND_VC: pass = !o;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == o);
      COND_LT: pass = (n != o);
      COND_GT: pass = !z & (n == o);
      COND_LE: pass = z | (n != o);
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU writeback stage: captures result/flags/dest, evaluates the condition at
// push time and buffers entries in a circular FIFO feeding the register file.
// Optional macro ALU_RESULT_BYPASS_EN: when empty, the live input is presented
// on the outputs in the same cycle and consumed without storage if accepted.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DEST_W = 3
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [31:0]              ALUOut,
  input  logic [3:0]               FlagsIn,
  input  logic [DEST_W-1:0]        DestSel,
  input  logic [3:0]               CondSel,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [31:0]              OutData,
  output logic [3:0]               OutFlags,
  output logic [DEST_W-1:0]        OutDest,
  output logic                     OutWrite,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            in_pass;
  entry_t          in_entry;
  entry_t          out_entry;
  logic            full, empty;
  logic            push_store, pop_fifo;

  alu_cond_eval u_cond (
    .flags (FlagsIn),
    .cond  (CondSel),
    .pass  (in_pass)
  );

  assign in_entry = '{data: ALUOut, flags: FlagsIn, dest: DEST_MAX_W'(DestSel), pass: in_pass};
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign InReady  = !full;
  assign pop_fifo = !empty & OutReady;

`ifdef ALU_RESULT_BYPASS_EN
  logic bypass;
  assign bypass     = empty & InValid;
  assign OutValid   = !empty | InValid;
  assign out_entry  = bypass ? in_entry : (empty ? '0 : mem_q[rd_ptr_q]);
  // A bypassed entry taken in the same cycle never enters storage.
  assign push_store = InValid & InReady & !(bypass & OutReady);
`else
  assign OutValid   = !empty;
  assign out_entry  = empty ? '0 : mem_q[rd_ptr_q];
  assign push_store = InValid & InReady;
`endif

  assign OutData  = out_entry.data;
  assign OutFlags = out_entry.flags;
  assign OutDest  = out_entry.dest[DEST_W-1:0];
  assign OutWrite = out_entry.pass;
  assign Count    = count_q;

  // Upper dest bits above DEST_W are always zero and intentionally not driven out.
  logic unused_dest;
  assign unused_dest = ^out_entry.dest;

  // Next-state: write at wr_ptr on push, advance rd_ptr on pop, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_store) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_fifo) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push_store) - CW'(pop_fifo);
  end

  // State registers; reset discards everything, including a handshake in the reset cycle.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage (default build, 1-cycle latency).
module tb_alu_result_stage;

  localparam int DEPTH  = 2;
  localparam int DEST_W = 3;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              Clock;
  logic              Reset;
  logic              InValid;
  logic              InReady;
  logic [31:0]       ALUOut;
  logic [3:0]        FlagsIn;
  logic [DEST_W-1:0] DestSel;
  logic [3:0]        CondSel;
  logic              OutValid;
  logic              OutReady;
  logic [31:0]       OutData;
  logic [3:0]        OutFlags;
  logic [DEST_W-1:0] OutDest;
  logic              OutWrite;
  logic [CW-1:0]     Count;

  alu_result_stage #(.DEPTH(DEPTH), .DEST_W(DEST_W)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .ALUOut   (ALUOut),
    .FlagsIn  (FlagsIn),
    .DestSel  (DestSel),
    .CondSel  (CondSel),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutData  (OutData),
    .OutFlags (OutFlags),
    .OutDest  (OutDest),
    .OutWrite (OutWrite),
    .Count    (Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0]       d;
    logic [3:0]        f;
    logic [DEST_W-1:0] ds;
    logic              w;
  } exp_t;

  exp_t exp_q[$];
  int   occ;
  int   n_cmp;
  int   n_err;

  // Reference condition table, flags given as {Z,C,N,O}.
  function automatic logic cond_ref(input logic [3:0] f, input logic [3:0] c);
    logic z, cy, n, o;
    z = f[3]; cy = f[2]; n = f[1]; o = f[0];
    case (c)
      4'd0:  return 1'b1;
      4'd1:  return z;
      4'd2:  return !z;
      4'd3:  return cy;
      4'd4:  return !cy;
      4'd5:  return n;
      4'd6:  return !n;
      4'd7:  return o;
      4'd8:  return !o;
      4'd9:  return cy && !z;
      4'd10: return !cy || z;
      4'd11: return n == o;
      4'd12: return n != o;
      4'd13: return !z && (n == o);
      4'd14: return z || (n != o);
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: whenever a head entry is presented, compare it to the oldest
  // expected entry; retire it when the register file accepts.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (Reset === 1'b1 && OutValid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 64'(OutValid), 64'(0));
        end else begin
          e = exp_q[0];
          chk("out_data",  64'(OutData),  64'(e.d));
          chk("out_flags", 64'(OutFlags), 64'(e.f));
          chk("out_dest",  64'(OutDest),  64'(e.ds));
          chk("out_write", 64'(OutWrite), 64'(e.w));
          if (OutReady) void'(exp_q.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; checks occupancy-level outputs and updates the model.
  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] f,
                      input logic [DEST_W-1:0] ds, input logic [3:0] c,
                      input logic rdy, input logic rn = 1'b1);
    int push, pop;
    exp_t e;
    InValid = v; ALUOut = d; FlagsIn = f; DestSel = ds; CondSel = c;
    OutReady = rdy; Reset = rn;
    @(negedge Clock);
    if (rn) begin
      chk("in_ready",  64'(InReady),  64'(occ < DEPTH));
      chk("count",     64'(Count),    64'(occ));
      chk("out_valid", 64'(OutValid), 64'(occ > 0));
      if (occ == 0) begin
        chk("empty_data",  64'(OutData),  64'(0));
        chk("empty_write", 64'(OutWrite), 64'(0));
      end
      push = (v && occ < DEPTH) ? 1 : 0;
      pop  = (rdy && occ > 0) ? 1 : 0;
      if (push == 1) begin
        e.d = d; e.f = f; e.ds = ds; e.w = cond_ref(f, c);
        exp_q.push_back(e);
      end
      occ = occ + push - pop;
    end else begin
      exp_q.delete();
      occ = 0;
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 4'h0, '0, 4'h0, rdy);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; occ = 0;
    Reset = 1'b0; InValid = 1'b0; ALUOut = '0; FlagsIn = '0; DestSel = '0;
    CondSel = '0; OutReady = 1'b0;
    repeat (2) @(posedge Clock);
    #1;

    // Reset state
    idle(1'b0);

    // Single push, AL condition
    step(1'b1, 32'h0000_0005, 4'b0000, 3'd3, 4'd0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Fill, overflow attempt, drain in order
    step(1'b1, 32'h1111_1111, 4'b0100, 3'd1, 4'd3, 1'b0);
    step(1'b1, 32'h2222_2222, 4'b0010, 3'd2, 4'd5, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 4'b1111, 3'd7, 4'd0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // Condition spot checks
    step(1'b1, 32'hA0, 4'b1000, 3'd0, 4'd1,  1'b1);
    step(1'b1, 32'hA1, 4'b1000, 3'd1, 4'd2,  1'b1);
    step(1'b1, 32'hA2, 4'b0011, 3'd2, 4'd11, 1'b1);
    step(1'b1, 32'hA3, 4'b0011, 3'd3, 4'd12, 1'b1);
    step(1'b1, 32'hA4, 4'b0011, 3'd4, 4'd13, 1'b1);
    idle(1'b1);

    // Occupancy 1 with push+pop every cycle: pointers wrap, order kept
    step(1'b1, 32'hB000_0000, 4'h0, 3'd5, 4'd0, 1'b0);
    for (int i = 1; i <= 8; i++)
      step(1'b1, 32'hB000_0000 + 32'(i), 4'(i), 3'(i), 4'(i), 1'b1);
    idle(1'b1);

    // Reset with a handshake in flight
    step(1'b1, 32'hC0, 4'h0, 3'd1, 4'd0, 1'b0);
    step(1'b1, 32'hC1, 4'h0, 3'd2, 4'd0, 1'b0);
    step(1'b1, 32'hC2, 4'h0, 3'd3, 4'd0, 1'b1, 1'b0);
    idle(1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, $urandom, 4'($urandom),
           DEST_W'($urandom), 4'($urandom),
           ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1);
    end

    // Drain
    repeat (4) idle(1'b1);
    chk("queue_drained", 64'(exp_q.size()), 64'(occ));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
